// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared keypad/alarm constants and entry-state encoding
package alarm_pkg;

    localparam logic [3:0] KEY_CLR    = 4'hA;
    localparam logic [3:0] KEY_ENT    = 4'hB;

    localparam logic [3:0] CMD_NONE   = 4'b0000;
    localparam logic [3:0] CMD_ARM    = 4'b0011;
    localparam logic [3:0] CMD_DISARM = 4'b1100;

    typedef enum bit [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_LOCKOUT = 2'd2
    } entry_state_t;

endpackage

// File: rtl/keypad_code_entry.sv
// rtl/keypad_code_entry.sv - PIN entry, arm/disarm decode, timeout and lockout
module keypad_code_entry
    import alarm_pkg::*;
#(
    parameter int                  DIGITS         = 4,
    parameter logic [4*DIGITS-1:0] ARM_CODE       = 16'h1234,
    parameter logic [4*DIGITS-1:0] DISARM_CODE    = 16'h4321,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  TIMEOUT_CYCLES = 100,
    parameter int                  LOCKOUT_CYCLES = 200
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            ENA,
    input  logic                            key_valid,
    input  logic [3:0]                      key_code,
    output logic [3:0]                      keypad_cmd,
    output logic                            entry_active,
    output logic                            locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int BW   = 4 * DIGITS;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX);

    entry_state_t  state;
    logic [BW-1:0] digit_buf;
    logic [CW-1:0] digit_cnt;
    // One timer serves both the entry timeout and the lockout period,
    // since ENTRY and LOCKOUT never overlap.
    logic [TW-1:0] timer;

    logic is_digit;
    logic buf_full;

    assign is_digit     = (key_code <= 4'd9);
    assign buf_full     = (digit_cnt == CW'(DIGITS));
    assign entry_active = (state == ST_ENTRY);
    assign locked_out   = (state == ST_LOCKOUT);

    // Entry state machine; everything holds while ENA is low.
    always_ff @(posedge clk) begin
        if (ENA) begin
            if (!reset) begin
                state      <= ST_IDLE;
                digit_buf  <= '0;
                digit_cnt  <= '0;
                timer      <= '0;
                fail_cnt   <= '0;
                keypad_cmd <= CMD_NONE;
            end else begin
                // Command is a single enabled-cycle pulse.
                keypad_cmd <= CMD_NONE;
                case (state)
                    ST_IDLE: begin
                        if (key_valid && is_digit) begin
                            digit_buf <= BW'(key_code);
                            digit_cnt <= CW'(1);
                            timer     <= '0;
                            state     <= ST_ENTRY;
                        end
                    end
                    ST_ENTRY: begin
                        if (key_valid) begin
                            // Any key, even an ignored code, restarts the timeout.
                            timer <= '0;
                            if (is_digit) begin
                                if (!buf_full) begin
                                    digit_buf <= (digit_buf << 4) | BW'(key_code);
                                    digit_cnt <= digit_cnt + CW'(1);
                                end
                            end else if (key_code == KEY_CLR) begin
                                digit_buf <= '0;
                                digit_cnt <= '0;
                                state     <= ST_IDLE;
                            end else if (key_code == KEY_ENT) begin
                                digit_buf <= '0;
                                digit_cnt <= '0;
                                if (buf_full && digit_buf == ARM_CODE) begin
                                    keypad_cmd <= CMD_ARM;
                                    fail_cnt   <= '0;
                                    state      <= ST_IDLE;
                                end else if (buf_full && digit_buf == DISARM_CODE) begin
                                    keypad_cmd <= CMD_DISARM;
                                    fail_cnt   <= '0;
                                    state      <= ST_IDLE;
                                end else begin
                                    fail_cnt <= fail_cnt + FW'(1);
                                    if (fail_cnt + FW'(1) == FW'(MAX_FAIL)) begin
                                        state <= ST_LOCKOUT;
                                    end else begin
                                        state <= ST_IDLE;
                                    end
                                end
                            end
                        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            digit_buf <= '0;
                            digit_cnt <= '0;
                            timer     <= '0;
                            state     <= ST_IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    ST_LOCKOUT: begin
                        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
                            timer    <= '0;
                            fail_cnt <= '0;
                            state    <= ST_IDLE;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/keypad_code_entry.md
# keypad_code_entry

Keypad front end for the alarm controller: collects digit key presses from the keypad scanner, checks a complete entry against the arm and disarm PINs, and issues the 4-bit command the alarm state machine consumes on its `keypad` input. The command is `4'b0011` for arm and `4'b1100` for disarm. The block adds an entry timeout and a lockout after repeated wrong codes. It sits directly upstream of the alarm controller and shares its `clk` and `ENA`.

## Interface
Parameters:
- `DIGITS`, 4: PIN length in keys.
- `ARM_CODE`, 16'h1234: arm PIN, BCD, first key in the most significant nibble.
- `DISARM_CODE`, 16'h4321: disarm PIN, same format.
- `MAX_FAIL`, 3: consecutive wrong entries that trigger lockout (≥1).
- `TIMEOUT_CYCLES`, 100: enabled cycles without a key before a partial entry is discarded (≥2).
- `LOCKOUT_CYCLES`, 200: enabled cycles spent in lockout (≥1).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low (0 = reset); sampled only when `ENA`=1.
- `ENA`  in  1  clock enable; when 0, all state holds and `key_valid` is ignored.
- `key_valid`  in  1  one-cycle strobe: `key_code` holds a new key.
- `key_code`  in  4  0–9 digit, `4'hA` CLR, `4'hB` ENT, `4'hC`–`4'hF` ignored.
- `keypad_cmd`  out  4  `4'b0011` arm, `4'b1100` disarm, `4'b0000` none; registered.
- `entry_active`  out  1  state == ENTRY.
- `locked_out`  out  1  state == LOCKOUT.
- `fail_cnt`  out  $clog2(MAX_FAIL+1)  consecutive wrong entries.

## Operation
States: IDLE, ENTRY, LOCKOUT. A "key" means `key_valid`=1 on an edge with `ENA`=1.

Reset (`reset`=0, `ENA`=1):
- state IDLE; digit buffer, digit count, timer and `fail_cnt` all 0.
- `keypad_cmd`=0, `entry_active`=0, `locked_out`=0.

IDLE:
- Digit: buffer={buffer[11:0],digit}, count=1, timer=0, go to ENTRY.
- CLR, ENT or codes C–F: ignored.

ENTRY:
- Digit with count<DIGITS: shift into buffer, count+1.
- Digit with count==DIGITS: not stored.
- CLR: clear buffer and count, go to IDLE. Not a failure.
- ENT, evaluated in priority order:
  - count==DIGITS and buffer==ARM_CODE: `keypad_cmd`=0011, `fail_cnt`=0, go to IDLE.
  - Else count==DIGITS and buffer==DISARM_CODE: `keypad_cmd`=1100, `fail_cnt`=0, go to IDLE.
  - Otherwise (including short entries): failure, `fail_cnt`+1. If the new value equals MAX_FAIL, go to LOCKOUT with timer=0; else go to IDLE.
  - In all ENT cases the buffer and count are cleared.
- ARM takes priority if ARM_CODE==DISARM_CODE.
- Timeout:
  - Any key (including ignored codes) clears the timer.
  - Each enabled cycle without a key increments the timer.
  - An enabled edge with timer==TIMEOUT_CYCLES-1 and no key clears the buffer and goes to IDLE. Not a failure.
  - A key on that same edge wins and the timeout is cancelled.

LOCKOUT:
- All keys are ignored.
- The timer increments each enabled cycle.
- On the edge where timer==LOCKOUT_CYCLES-1: go to IDLE, `fail_cnt`=0.
- `fail_cnt` reads MAX_FAIL throughout lockout.

`keypad_cmd` returns to 0000 on the next enabled edge after it is set.

## Timing
- ENT on enabled edge N sets `keypad_cmd` after edge N; it clears at the next enabled edge.
  - The pulse therefore spans exactly one enabled cycle and stretches across any `ENA`=0 cycles. The downstream controller sees it exactly once.
- `entry_active` and `locked_out` are decoded directly from the state register, so they change with the same edge as the state.
- Timeout: with the last key on edge N, the abort happens on enabled edge N+TIMEOUT_CYCLES.
- Lockout: entered on edge N, left on enabled edge N+LOCKOUT_CYCLES.
- A keypress during the lockout-exit edge is ignored.
- Reset mid-entry or mid-lockout takes effect on that enabled edge. Any pending command is dropped.
- Counters never wrap: `fail_cnt` saturates at MAX_FAIL, and the timer is cleared on every state change.

## Structure
- Shared package `alarm_pkg` holds:
  - Constants `KEY_CLR`=4'hA, `KEY_ENT`=4'hB, `CMD_NONE`=4'b0000, `CMD_ARM`=4'b0011, `CMD_DISARM`=4'b1100.
  - The entry-state enum (`bit [1:0]`).
- The alarm controller is to import the same command constants.
- No sub-module. ENTRY and LOCKOUT are exclusive, so one shared timer sized `$clog2(max(TIMEOUT_CYCLES,LOCKOUT_CYCLES))` serves both.

## Test plan
Bench parameters: TIMEOUT_CYCLES=8, LOCKOUT_CYCLES=10, MAX_FAIL=3; `ENA`=1 unless stated.
- Keys 1,2,3,4,ENT: `keypad_cmd`=0011 for exactly one cycle after ENT, `fail_cnt`=0. Then 4,3,2,1,ENT: 1100 for one cycle.
- Keys 1,2,3,ENT: failure, `fail_cnt`=1, no command. Keys 1,2,3,4,5,ENT: fifth digit dropped, `keypad_cmd`=0011.
- Three wrong entries: `locked_out`=1 after the third ENT. Keys 1,2,3,4,ENT during lockout give no command. `locked_out` drops exactly 10 cycles later with `fail_cnt`=0.
- Keys 1,2 then idle: `entry_active` drops at edge 8 after the last key, `fail_cnt` unchanged. A key at timer=7 keeps ENTRY.
- Keys 1,2,3,4,ENT with `ENA` toggling 1010…: `keypad_cmd` held until the next enabled edge. Keys presented while `ENA`=0 are ignored.
- `reset`=0 mid-entry after 1,2: IDLE and all outputs 0. Then 3,4,ENT is a short-entry failure.
